// File: rtl/rv32i_types.sv
// Shared types for the memory arbiter: FSM state and the latched memory request.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between the fetch (imem) and data (dmem) ports.
// Data has priority, bounded by a streak counter so fetch always makes progress.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic [31:0] dstreak_stall
);

  localparam logic [3:0] MaxStreak = 4'(MAX_DSTREAK);

  arb_state_t  state_q;
  mem_req_t    req_q;
  logic [3:0]  streak_q;
  logic [31:0] stall_q;
  logic        withdrawn_q;

  logic     imem_req, dmem_req, imem_waiting;
  logic     grant_i, grant_d, done;
  mem_req_t ireq, dreq;

  assign imem_req = |imem_rmask;
  assign dmem_req = (|dmem_rmask) || (|dmem_wmask);
  // In its own resp cycle the fetch mask is stale, so imem is not counted as waiting.
  assign imem_waiting = imem_req && (state_q != BUSY_I);
  assign done = mem_resp && (state_q != IDLE);

  always_comb begin
    ireq = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0, wdata: 32'h0};
    dreq = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};
  end

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dmem_req && (!imem_req || (streak_q < MaxStreak))) begin
          grant_d = 1'b1;
        end else if (imem_req) begin
          grant_i = 1'b1;
        end
      end
      BUSY_I:  grant_d = mem_resp && dmem_req;
      BUSY_D:  grant_i = mem_resp && imem_req;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      streak_q    <= 4'h0;
      stall_q     <= 32'h0;
      withdrawn_q <= 1'b0;
    end else begin
      if ((state_q == BUSY_D) && imem_req) begin
        stall_q <= stall_q + 32'd1;
      end
      if (grant_d) begin
        state_q     <= BUSY_D;
        req_q       <= dreq;
        withdrawn_q <= 1'b0;
        if (!imem_waiting) begin
          streak_q <= 4'h0;
        end else if (streak_q < MaxStreak) begin
          streak_q <= streak_q + 4'd1;
        end
      end else if (grant_i) begin
        state_q     <= BUSY_I;
        req_q       <= ireq;
        withdrawn_q <= 1'b0;
        streak_q    <= 4'h0;
      end else if (done) begin
        state_q     <= IDLE;
        req_q.rmask <= 4'h0;
        req_q.wmask <= 4'h0;
      end else if (((state_q == BUSY_I) && !imem_req) || ((state_q == BUSY_D) && !dmem_req)) begin
        // Requester flushed its access; the memory op still finishes but is not reported.
        withdrawn_q <= 1'b1;
      end
    end
  end

  always_comb begin
    imem_resp  = (state_q == BUSY_I) && mem_resp && imem_req && !withdrawn_q;
    dmem_resp  = (state_q == BUSY_D) && mem_resp && dmem_req && !withdrawn_q;
    imem_rdata = imem_resp ? mem_rdata : 32'h0;
    dmem_rdata = dmem_resp ? mem_rdata : 32'h0;
  end

  assign mem_addr      = req_q.addr;
  assign mem_rmask     = req_q.rmask;
  assign mem_wmask     = req_q.wmask;
  assign mem_wdata     = req_q.wdata;
  assign dstreak_stall = stall_q;

  // A data access is either a load or a store, never both.
  dmem_mask_excl: assert property (@(posedge clk) disable iff (!rst)
    !((|dmem_rmask) && (|dmem_wmask)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned MaxD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
  logic        imem_resp, dmem_resp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, dstreak_stall;
  logic [3:0]  mem_rmask, mem_wmask;
  logic        mem_resp;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.MAX_DSTREAK(MaxD)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .dstreak_stall(dstreak_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_addr  = 32'h0;
    imem_rmask = 4'h0;
    dmem_addr  = 32'h0;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
    dmem_wdata = 32'h0;
    mem_rdata  = 32'h0;
    mem_resp   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #3;
    checks++;
    if ({mem_addr, mem_rmask, mem_wmask, mem_wdata} !== 72'h0) begin
      failures++;
      $display("FAIL reset_mem: got addr=%h rm=%h wm=%h wd=%h want all 0",
               mem_addr, mem_rmask, mem_wmask, mem_wdata);
    end
    checks++;
    if ({imem_resp, dmem_resp, imem_rdata, dmem_rdata, dstreak_stall} !== 98'h0) begin
      failures++;
      $display("FAIL reset_resp: got iresp=%b dresp=%b ird=%h drd=%h stall=%0d want 0",
               imem_resp, dmem_resp, imem_rdata, dmem_rdata, dstreak_stall);
    end
    tick();
    rst = 1'b1;
    // Idle for 10 cycles; stray mem_resp pulses in IDLE must be ignored.
    for (int k = 0; k < 10; k++) begin
      mem_resp  = 1'(k % 2);
      mem_rdata = $urandom;
      #1;
      checks++;
      if ({mem_addr, mem_rmask, mem_wmask, mem_wdata, imem_resp, dmem_resp,
           imem_rdata, dmem_rdata, dstreak_stall} !== 170'h0) begin
        failures++;
        $display("FAIL idle_zero cyc %0d: addr=%h rm=%h wm=%h iresp=%b dresp=%b ird=%h drd=%h want 0",
                 k, mem_addr, mem_rmask, mem_wmask, imem_resp, dmem_resp, imem_rdata, dmem_rdata);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_fetch();
    do_reset();
    imem_addr  = 32'h1eceb000;
    imem_rmask = 4'hF;
    tick();
    checks++;
    if (mem_addr !== 32'h1eceb000 || mem_rmask !== 4'hF || mem_wmask !== 4'h0) begin
      failures++;
      $display("FAIL fetch_issue: addr=%h rm=%h wm=%h want 1eceb000 f 0",
               mem_addr, mem_rmask, mem_wmask);
    end
    tick();
    tick();
    mem_resp  = 1'b1;
    mem_rdata = 32'h00000013;
    #1;
    checks++;
    if (imem_resp !== 1'b1 || imem_rdata !== 32'h00000013 || dmem_resp !== 1'b0) begin
      failures++;
      $display("FAIL fetch_resp: iresp=%b ird=%h dresp=%b want 1 00000013 0",
               imem_resp, imem_rdata, dmem_resp);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (mem_rmask !== 4'h0 || imem_resp !== 1'b0 || imem_rdata !== 32'h0) begin
      failures++;
      $display("FAIL fetch_done: rm=%h iresp=%b ird=%h want 0 0 0", mem_rmask, imem_resp, imem_rdata);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    imem_addr  = 32'h1eceb004;
    imem_rmask = 4'hF;
    dmem_addr  = 32'h1ecec000;
    dmem_wmask = 4'h3;
    dmem_wdata = 32'h0000BEEF;
    tick();
    checks++;
    if (mem_addr !== 32'h1ecec000 || mem_wmask !== 4'h3 || mem_rmask !== 4'h0 ||
        mem_wdata !== 32'h0000BEEF) begin
      failures++;
      $display("FAIL sim_dgrant: addr=%h rm=%h wm=%h wd=%h want 1ecec000 0 3 0000beef",
               mem_addr, mem_rmask, mem_wmask, mem_wdata);
    end
    tick();
    mem_resp  = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (dmem_resp !== 1'b1 || imem_resp !== 1'b0) begin
      failures++;
      $display("FAIL sim_dresp: dresp=%b iresp=%b want 1 0", dmem_resp, imem_resp);
    end
    tick();
    mem_resp   = 1'b0;
    dmem_wmask = 4'h0;
    #1;
    checks++;
    if (mem_addr !== 32'h1eceb004 || mem_rmask !== 4'hF || mem_wmask !== 4'h0 ||
        mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL sim_b2b_igrant: addr=%h rm=%h wm=%h wd=%h want 1eceb004 f 0 0",
               mem_addr, mem_rmask, mem_wmask, mem_wdata);
    end
    checks++;
    if (dstreak_stall !== 32'd2) begin
      failures++;
      $display("FAIL sim_stall: got %0d want 2", dstreak_stall);
    end
    mem_resp  = 1'b1;
    mem_rdata = 32'h00000055;
    #1;
    checks++;
    if (imem_resp !== 1'b1 || imem_rdata !== 32'h00000055) begin
      failures++;
      $display("FAIL sim_iresp: iresp=%b ird=%h want 1 00000055", imem_resp, imem_rdata);
    end
    tick();
    clear_inputs();
  endtask

  // Both ports request continuously: back-to-back handoff alternates the grants.
  task automatic test_back_to_back();
    logic [31:0] want;
    do_reset();
    dmem_addr  = 32'h00002000;
    dmem_rmask = 4'hF;
    imem_addr  = 32'h00001000;
    imem_rmask = 4'hF;
    tick();
    for (int g = 0; g < 6; g++) begin
      want = (g % 2 == 0) ? 32'h00002000 : 32'h00001000;
      checks++;
      if (mem_addr !== want) begin
        failures++;
        $display("FAIL b2b_grant %0d: addr=%h want %h", g, mem_addr, want);
      end
      tick();
      mem_resp  = 1'b1;
      mem_rdata = 32'h100 + 32'(g);
      #1;
      checks++;
      if (imem_resp !== (g % 2 == 1) || dmem_resp !== (g % 2 == 0)) begin
        failures++;
        $display("FAIL b2b_resp %0d: iresp=%b dresp=%b want %b %b",
                 g, imem_resp, dmem_resp, (g % 2 == 1), (g % 2 == 0));
      end
      tick();
      mem_resp = 1'b0;
    end
    checks++;
    if (dstreak_stall !== 32'd6) begin
      failures++;
      $display("FAIL b2b_stall: got %0d want 6", dstreak_stall);
    end
    clear_inputs();
  endtask

  // imem is waiting at every IDLE decision; after MaxD data grants fetch is forced.
  task automatic test_streak();
    logic [31:0] want;
    do_reset();
    dmem_addr  = 32'h1ecec100;
    dmem_wmask = 4'hF;
    dmem_wdata = 32'h11;
    imem_addr  = 32'h1eceb200;
    for (int k = 0; k <= int'(MaxD); k++) begin
      imem_rmask = 4'hF;
      tick();
      want = (k < int'(MaxD)) ? 32'h1ecec100 : 32'h1eceb200;
      checks++;
      if (mem_addr !== want) begin
        failures++;
        $display("FAIL streak_grant %0d: addr=%h want %h", k, mem_addr, want);
      end
      if (k < int'(MaxD)) begin
        imem_rmask = 4'h0;
        mem_resp   = 1'b1;
        tick();
        mem_resp = 1'b0;
      end
    end
    mem_resp  = 1'b1;
    mem_rdata = 32'h77;
    #1;
    checks++;
    if (imem_resp !== 1'b1 || imem_rdata !== 32'h77) begin
      failures++;
      $display("FAIL streak_iresp: iresp=%b ird=%h want 1 00000077", imem_resp, imem_rdata);
    end
    tick();
    mem_resp   = 1'b0;
    imem_rmask = 4'h0;
    #1;
    checks++;
    if (mem_addr !== 32'h1ecec100 || mem_wmask !== 4'hF) begin
      failures++;
      $display("FAIL streak_resume: addr=%h wm=%h want 1ecec100 f", mem_addr, mem_wmask);
    end
    clear_inputs();
  endtask

  task automatic test_withdraw();
    do_reset();
    imem_addr  = 32'h1eceb300;
    imem_rmask = 4'hF;
    tick();
    imem_rmask = 4'h0;
    tick();
    mem_resp  = 1'b1;
    mem_rdata = 32'h1234;
    #1;
    checks++;
    if (imem_resp !== 1'b0 || imem_rdata !== 32'h0 || dmem_resp !== 1'b0) begin
      failures++;
      $display("FAIL withdraw_resp: iresp=%b ird=%h dresp=%b want 0 0 0",
               imem_resp, imem_rdata, dmem_resp);
    end
    tick();
    mem_resp = 1'b0;
    tick();
    checks++;
    if (mem_rmask !== 4'h0 || mem_wmask !== 4'h0) begin
      failures++;
      $display("FAIL withdraw_idle: rm=%h wm=%h want 0 0", mem_rmask, mem_wmask);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    dmem_addr  = 32'h1ecec200;
    dmem_wmask = 4'hF;
    dmem_wdata = 32'hCAFE;
    tick();
    checks++;
    if (mem_wmask !== 4'hF) begin
      failures++;
      $display("FAIL rstmid_pre: wm=%h want f", mem_wmask);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_wmask !== 4'h0 || mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_async: wm=%h addr=%h want 0 0", mem_wmask, mem_addr);
    end
    dmem_wmask = 4'h0;
    tick();
    rst        = 1'b1;
    imem_addr  = 32'h1eceb100;
    imem_rmask = 4'hF;
    tick();
    checks++;
    if (mem_addr !== 32'h1eceb100 || mem_rmask !== 4'hF) begin
      failures++;
      $display("FAIL rstmid_fetch: addr=%h rm=%h want 1eceb100 f", mem_addr, mem_rmask);
    end
    mem_resp  = 1'b1;
    mem_rdata = 32'h93;
    #1;
    checks++;
    if (imem_resp !== 1'b1 || imem_rdata !== 32'h93) begin
      failures++;
      $display("FAIL rstmid_iresp: iresp=%b ird=%h want 1 00000093", imem_resp, imem_rdata);
    end
    tick();
    clear_inputs();
  endtask

  // Random requesters and memory latency against a transaction-level model.
  task automatic test_random();
    int          owner = 0;   // 0 none, 1 fetch, 2 data
    bit          live = 1'b0;
    int          streak = 0;
    int          grant;
    logic [31:0] e_addr = 32'h0, e_wd = 32'h0, e_stall = 32'h0, rd;
    logic [3:0]  e_rm = 4'h0, e_wm = 4'h0;
    bit          i_pend = 1'b0, d_pend = 1'b0, e_ir, e_dr, i_wait;
    logic [31:0] i_a = 32'h0, d_a = 32'h0, d_wd = 32'h0;
    logic [3:0]  d_rm = 4'h0, d_wm = 4'h0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!i_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          i_pend = 1'b1;
          i_a    = $urandom & 32'hFFFF_FFFC;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        i_pend = 1'b0;
      end
      if (!d_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          d_pend = 1'b1;
          d_a    = $urandom;
          d_wd   = $urandom;
          if ($urandom_range(0, 1) == 0) begin
            d_wm = 4'($urandom_range(1, 15));
            d_rm = 4'h0;
          end else begin
            d_rm = 4'($urandom_range(1, 15));
            d_wm = 4'h0;
          end
        end
      end else if ($urandom_range(0, 7) == 0) begin
        d_pend = 1'b0;
      end
      rd         = $urandom;
      mem_resp   = (owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      mem_rdata  = rd;
      imem_addr  = i_a;
      imem_rmask = i_pend ? 4'hF : 4'h0;
      dmem_addr  = d_a;
      dmem_wdata = d_wd;
      dmem_rmask = d_pend ? d_rm : 4'h0;
      dmem_wmask = d_pend ? d_wm : 4'h0;
      #1;
      e_ir = (owner == 1) && mem_resp && live && i_pend;
      e_dr = (owner == 2) && mem_resp && live && d_pend;
      checks++;
      if (imem_resp !== e_ir || imem_rdata !== (e_ir ? rd : 32'h0)) begin
        failures++;
        $display("FAIL rnd_imem cyc %0d: iresp=%b ird=%h want %b %h",
                 c, imem_resp, imem_rdata, e_ir, e_ir ? rd : 32'h0);
      end
      checks++;
      if (dmem_resp !== e_dr || dmem_rdata !== (e_dr ? rd : 32'h0)) begin
        failures++;
        $display("FAIL rnd_dmem cyc %0d: dresp=%b drd=%h want %b %h",
                 c, dmem_resp, dmem_rdata, e_dr, e_dr ? rd : 32'h0);
      end
      checks++;
      if (mem_addr !== e_addr || mem_rmask !== e_rm || mem_wmask !== e_wm ||
          mem_wdata !== e_wd || dstreak_stall !== e_stall) begin
        failures++;
        $display("FAIL rnd_mem cyc %0d: addr=%h rm=%h wm=%h wd=%h stall=%0d want %h %h %h %h %0d",
                 c, mem_addr, mem_rmask, mem_wmask, mem_wdata, dstreak_stall,
                 e_addr, e_rm, e_wm, e_wd, e_stall);
      end
      // Advance the model across the coming clock edge.
      i_wait = i_pend && (owner != 1);
      if (owner == 2 && i_pend) e_stall = e_stall + 32'd1;
      grant = 0;
      if (owner == 0) begin
        if (d_pend && (!i_pend || streak < int'(MaxD))) grant = 2;
        else if (i_pend) grant = 1;
      end else if (mem_resp) begin
        if (owner == 1 && d_pend) grant = 2;
        if (owner == 2 && i_pend) grant = 1;
      end
      if (grant == 2) begin
        streak = i_wait ? ((streak < int'(MaxD)) ? streak + 1 : streak) : 0;
        owner = 2; live = 1'b1;
        e_addr = d_a; e_rm = d_rm; e_wm = d_wm; e_wd = d_wd;
      end else if (grant == 1) begin
        streak = 0;
        owner = 1; live = 1'b1;
        e_addr = i_a; e_rm = 4'hF; e_wm = 4'h0; e_wd = 32'h0;
      end else if (owner != 0 && mem_resp) begin
        owner = 0; e_rm = 4'h0; e_wm = 4'h0;
      end else if ((owner == 1 && !i_pend) || (owner == 2 && !d_pend)) begin
        live = 1'b0;
      end
      if (e_ir) i_pend = 1'b0;
      if (e_dr) d_pend = 1'b0;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fetch();
    test_simultaneous();
    test_back_to_back();
    test_streak();
    test_withdraw();
    test_reset_mid_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-ported memory interface between the pipeline's instruction port and data port. The pipelined `cpu` drives `imem_*` and `dmem_*` into this block, and the block drives the physical memory. The block registers the granted request, holds it stable until the memory responds, then steers the response back to the winner. Data requests have priority, bounded by an anti-starvation counter so fetch always makes progress.

## Interface
Parameters:
- `MAX_DSTREAK`, default 4: maximum consecutive dmem grants while imem is waiting before imem is forced. Legal range 1..15.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `imem_addr`  in  32  fetch address.
- `imem_rmask`  in  4  fetch byte mask; nonzero = request.
- `imem_rdata`  out  32  fetch data.
- `imem_resp`  out  1  one-cycle fetch completion.
- `dmem_addr`  in  32  data address.
- `dmem_rmask`  in  4  load mask.
- `dmem_wmask`  in  4  store mask; request = rmask or wmask nonzero.
- `dmem_wdata`  in  32  store data.
- `dmem_rdata`  out  32  load data.
- `dmem_resp`  out  1  one-cycle data completion.
- `mem_addr`  out  32  registered address to memory.
- `mem_rmask`  out  4  registered read mask.
- `mem_wmask`  out  4  registered write mask.
- `mem_wdata`  out  32  registered store data.
- `mem_rdata`  in  32  memory read data, valid with `mem_resp`.
- `mem_resp`  in  1  one-cycle memory completion.
- `dstreak_stall`  out  32  count of cycles imem waited while dmem was granted. Debug only; wraps at 2^32.

## Operation
FSM states: IDLE, BUSY_I, BUSY_D.

IDLE behaviour:
- dmem requesting and (imem idle or streak < MAX_DSTREAK): grant D.
- Else if imem requesting: grant I.
- Else: stay in IDLE.

Grant:
- Latch the winner's addr/masks/wdata into the `mem_*` registers and move to BUSY_x.
- For an I grant, `mem_wmask`=0 and `mem_wdata`=0.

BUSY_x:
- `mem_*` are held constant, and masks stay level until `mem_resp`.
- On `mem_resp`:
  - Drive x_resp=1 combinationally the same cycle.
  - Pass `mem_rdata` to x_rdata.
  - Clear the `mem_*` masks.
  - If the *other* requester is requesting this cycle, grant it at this edge (back-to-back). Otherwise go to IDLE.
  - Never regrant the just-completed requester in its own resp cycle, because its request is stale.

Streak counter (4-bit):
- Increments on each D grant made while imem is requesting.
- Clears on any I grant, or on any D grant made while imem is idle.
- Saturates at MAX_DSTREAK.

Withdrawal:
- If the granted requester's masks drop to zero while BUSY, the memory transaction still completes.
- `mem_resp` is consumed and no x_resp is pulsed.

Response data:
- x_rdata = `mem_rdata` when x_resp, else 0.
- Store completion still pulses `dmem_resp`; its rdata is don't-care (driven from `mem_rdata`).

Illegal inputs:
- `dmem_rmask` and `dmem_wmask` both nonzero is illegal; flag it with an assertion.
- `mem_resp` in IDLE is ignored.

## Timing
- Reset (`rst`=0, async): state IDLE; streak 0; all `mem_*` 0; both resp 0; both rdata 0; `dstreak_stall` 0.
- Request visible in IDLE at cycle N: `mem_*` valid at N+1.
- `mem_resp` at cycle M: x_resp at M, zero added latency.
- Back-to-back: the other requester's `mem_*` are valid at M+1.
- Minimum turnaround for one requester issuing consecutive accesses: resp at M, IDLE at M+1, `mem_*` at M+2.
- Simultaneous I and D requests in IDLE: D wins unless streak == MAX_DSTREAK.
- Requesters must hold request fields stable from assertion until their resp; only the masks may drop (withdrawal).
- Reset mid-BUSY: the transaction is abandoned and masks clear immediately. The memory model must tolerate the drop.

## Structure
- Add to `rv32i_types`: `arb_state_t` enum {IDLE, BUSY_I, BUSY_D}.
- Add to `rv32i_types`: `mem_req_t` struct {addr[31:0], rmask[3:0], wmask[3:0], wdata[31:0]}. It is used for the latched request register and the winner mux.
- Single module; no sub-module is needed.
- The `cpu` top keeps its current ports. A new top instantiates `cpu` plus `mem_arbiter` to drive a unified memory model.

## Test plan
- Reset with `mem_*` probed → all zero, state IDLE; deassert `rst` with no requests → outputs remain zero for 10 cycles.
- imem request addr 0x1eceb000, rmask 0xF; memory responds 3 cycles later with 0x00000013 → `mem_addr`=0x1eceb000 at N+1; `imem_resp`=1 and `imem_rdata`=0x00000013 on the same cycle as `mem_resp`.
- Simultaneous imem 0x1eceb004 and dmem store addr 0x1ecec000 wmask 0x3 wdata 0xBEEF → D granted first, `mem_wmask`=0x3. On D resp, I is granted at the next edge with `mem_addr`=0x1eceb004.
- dmem requests continuously, imem always pending, MAX_DSTREAK=4 → exactly 4 D grants, then 1 I grant, then D resumes. `dstreak_stall` increments on every cycle imem waited.
- Granted imem drops rmask to 0 mid-BUSY (branch flush) → `mem_resp` arrives with no `imem_resp` pulse, then FSM returns to IDLE.
- Assert `rst` low during BUSY_D → `mem_wmask` is 0 within the same cycle, asynchronously; after release, a fresh imem request completes normally.
